actuator_put: RTL and testbench

//  Output-side counterpart of the sensor input stage in the fuzzy controller datapath.

---
 rtl/fuzzy_ctl_pkg.sv | 27 ++
 rtl/actuator_put_pwm_gen.sv | 34 +++
 rtl/actuator_put.sv | 181 ++++++++++++++++++
 tb/tb_actuator_put.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fuzzy_ctl_pkg.sv
// Shared types and error-bit layout for the fuzzy controller datapath.
// The input stage and the actuator output stage both use these definitions.
package fuzzy_ctl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SLEW = 1'b1
  } state_t;

  localparam int ERR_RANGE = 0;
  localparam int ERR_STALL = 1;
  localparam int ERR_W     = 2;

  // Sticky error bit: a set event beats a concurrent clear.
  function automatic logic stickyNext(input logic cur, input logic set, input logic clr);
    logic nxt;
    if (set) begin
      nxt = 1'b1;
    end else if (clr) begin
      nxt = 1'b0;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/actuator_put_pwm_gen.sv
// Free-running PWM counter with registered compare output.
// PeriodEnd marks the last count of each period, so duty changes land on a period boundary.
module pwm_gen #(
  parameter int Width = 10
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [Width-1:0] Duty,
  output logic             PwmOut,
  output logic             PeriodEnd
);

  localparam logic [Width-1:0] CNT_MAX  = {Width{1'b1}};
  localparam logic [Width-1:0] CNT_ONE  = Width'(1);
  localparam logic [Width-1:0] CNT_ZERO = {Width{1'b0}};

  logic [Width-1:0] cnt_r;
  logic             pwm_r;

  assign PeriodEnd = (cnt_r == CNT_MAX);
  assign PwmOut    = pwm_r;

  // Counter wraps naturally; output compares against the duty of the current period.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_r <= CNT_ZERO;
      pwm_r <= 1'b0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
      pwm_r <= (cnt_r < Duty);
    end
  end

endmodule

// File: rtl/actuator_put.sv
// Actuator output stage: accepts a command, clamps it, slew-limits the applied duty
// once per PWM period, and reports range clamps and handshake stalls as sticky errors.
module actuator_put
  import fuzzy_ctl_pkg::*;
#(
  parameter int ActuatorPut_LimitBit = 10,
  parameter int BaseUpBound          = 1023,
  parameter int BaseDownBound        = 0,
  parameter int SlewStep             = 10,
  parameter int StallLimit           = 2048
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic [ActuatorPut_LimitBit-1:0] CmdValue,
  input  logic                            CmdValid,
  output logic                            CmdReady,
  input  logic                            ErrorClear,
  output logic [ActuatorPut_LimitBit-1:0] AppliedValue,
  output logic                            PwmOut,
  output logic [ERR_W-1:0]                ErrorReturn
);

  localparam int N  = ActuatorPut_LimitBit;
  localparam int SW = $clog2(StallLimit + 1);

  localparam logic [N:0]    UP_EXT      = (N+1)'(BaseUpBound);
  localparam logic [N:0]    DOWN_EXT_P1 = (N+1)'(BaseDownBound + 1);
  localparam logic [N:0]    ONE_EXT     = (N+1)'(1);
  localparam logic [N:0]    STEP_EXT    = (N+1)'(SlewStep);
  localparam logic [N-1:0]  UP_N        = N'(BaseUpBound);
  localparam logic [N-1:0]  DOWN_N      = N'(BaseDownBound);
  localparam logic [N-1:0]  STEP_N      = N'(SlewStep);
  localparam logic [N-1:0]  ZERO_N      = {N{1'b0}};
  localparam logic [SW-1:0] STALL_MAX   = SW'(StallLimit);
  localparam logic [SW-1:0] STALL_ONE   = SW'(1);
  localparam logic [SW-1:0] STALL_ZERO  = {SW{1'b0}};

  state_t           state_r, stateNext_s;
  logic [N-1:0]     target_r, targetNext_s;
  logic [N-1:0]     applied_r, appliedNext_s;
  logic             cmdReady_r;
  logic [ERR_W-1:0] err_r, errNext_s;
  logic [SW-1:0]    stallCnt_r, stallNext_s;
  logic [N:0]       cmdExt_s;
  logic             clampHi_s, clampLo_s;
  logic [N-1:0]     cmdClamp_s;
  logic [N-1:0]     diff_s, slewNext_s;
  logic             accept_s, rangeSet_s, stallCond_s, stallSet_s;
  logic             periodEnd_s;

  assign accept_s    = CmdValid && cmdReady_r;
  assign cmdExt_s    = {1'b0, CmdValue};
  assign clampHi_s   = (cmdExt_s > UP_EXT);
  // Offset by one so a zero lower bound does not produce a degenerate unsigned compare.
  assign clampLo_s   = ((cmdExt_s + ONE_EXT) < DOWN_EXT_P1);
  assign rangeSet_s  = accept_s && (clampHi_s || clampLo_s);
  assign stallCond_s = CmdValid && !cmdReady_r;
  assign stallSet_s  = (stallCnt_r == STALL_MAX);

  // Clamp the incoming command to the legal window.
  always_comb begin
    cmdClamp_s = CmdValue;
    if (clampHi_s) begin
      cmdClamp_s = UP_N;
    end else if (clampLo_s) begin
      cmdClamp_s = DOWN_N;
    end else begin
      cmdClamp_s = CmdValue;
    end
  end

  // One slew step toward the target; a short remaining distance lands exactly on it.
  always_comb begin
    diff_s      = ZERO_N;
    slewNext_s  = applied_r;
    if (target_r > applied_r) begin
      diff_s = target_r - applied_r;
      if ({1'b0, diff_s} > STEP_EXT) begin
        slewNext_s = applied_r + STEP_N;
      end else begin
        slewNext_s = target_r;
      end
    end else if (target_r < applied_r) begin
      diff_s = applied_r - target_r;
      if ({1'b0, diff_s} > STEP_EXT) begin
        slewNext_s = applied_r - STEP_N;
      end else begin
        slewNext_s = target_r;
      end
    end else begin
      slewNext_s = applied_r;
    end
  end

  // Next-state logic: IDLE takes commands, SLEW steps only at a PWM period end.
  always_comb begin
    stateNext_s   = state_r;
    targetNext_s  = target_r;
    appliedNext_s = applied_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          targetNext_s = cmdClamp_s;
          if (cmdClamp_s != applied_r) begin
            stateNext_s = ST_SLEW;
          end else begin
            stateNext_s = ST_IDLE;
          end
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_SLEW: begin
        if (periodEnd_s) begin
          appliedNext_s = slewNext_s;
          if (slewNext_s == target_r) begin
            stateNext_s = ST_IDLE;
          end else begin
            stateNext_s = ST_SLEW;
          end
        end else begin
          stateNext_s = ST_SLEW;
        end
      end
      default: begin
        stateNext_s = ST_IDLE;
      end
    endcase
  end

  // Saturating stall counter and sticky error bits.
  always_comb begin
    stallNext_s = STALL_ZERO;
    if (stallCond_s) begin
      if (stallCnt_r == STALL_MAX) begin
        stallNext_s = stallCnt_r;
      end else begin
        stallNext_s = stallCnt_r + STALL_ONE;
      end
    end else begin
      stallNext_s = STALL_ZERO;
    end
    errNext_s            = err_r;
    errNext_s[ERR_RANGE] = stickyNext(err_r[ERR_RANGE], rangeSet_s, ErrorClear);
    errNext_s[ERR_STALL] = stickyNext(err_r[ERR_STALL], stallSet_s, ErrorClear);
  end

  // State registers; reset drops any slew in progress.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r    <= ST_IDLE;
      target_r   <= DOWN_N;
      applied_r  <= DOWN_N;
      cmdReady_r <= 1'b1;
      err_r      <= {ERR_W{1'b0}};
      stallCnt_r <= STALL_ZERO;
    end else begin
      state_r    <= stateNext_s;
      target_r   <= targetNext_s;
      applied_r  <= appliedNext_s;
      cmdReady_r <= (stateNext_s == ST_IDLE);
      err_r      <= errNext_s;
      stallCnt_r <= stallNext_s;
    end
  end

  pwm_gen #(
    .Width(N)
  ) uPwm (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Duty     (applied_r),
    .PwmOut   (PwmOut),
    .PeriodEnd(periodEnd_s)
  );

  assign CmdReady     = cmdReady_r;
  assign AppliedValue = applied_r;
  assign ErrorReturn  = err_r;

endmodule

// File: tb/tb_actuator_put.sv
// Directed bench for actuator_put: default instance plus a clamp instance
// (BaseUpBound=1000, large step) so the clamp landing is reached in a few periods.
module tb_actuator_put;

  logic       clk = 1'b0;
  logic       rstN;
  logic [9:0] aCmd, bCmd;
  logic       aValid, bValid, aClear, bClear;
  logic       aReady, bReady, aPwm, bPwm;
  logic [9:0] aApplied, bApplied;
  logic [1:0] aErr, bErr;
  logic [9:0] tbCnt;
  int         nChecks = 0;
  int         nFails  = 0;

  always #5 clk = ~clk;

  actuator_put dutA (
    .Clk(clk), .Rst_n(rstN), .CmdValue(aCmd), .CmdValid(aValid), .CmdReady(aReady),
    .ErrorClear(aClear), .AppliedValue(aApplied), .PwmOut(aPwm), .ErrorReturn(aErr)
  );

  actuator_put #(
    .BaseUpBound(1000), .SlewStep(330)
  ) dutB (
    .Clk(clk), .Rst_n(rstN), .CmdValue(bCmd), .CmdValid(bValid), .CmdReady(bReady),
    .ErrorClear(bClear), .AppliedValue(bApplied), .PwmOut(bPwm), .ErrorReturn(bErr)
  );

  // Reference PWM phase: mirrors the free-running period counter.
  always @(posedge clk) begin
    if (!rstN) tbCnt <= 10'd0;
    else       tbCnt <= tbCnt + 10'd1;
  end

  task automatic checkVal(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for the applied value to change, then check it and that it changed on a wrap.
  task automatic waitStep(input bit useB, input int exp, input string tag);
    int prev;
    int cur;
    prev = useB ? int'(bApplied) : int'(aApplied);
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      cur = useB ? int'(bApplied) : int'(aApplied);
      if (cur != prev) break;
    end
    cur = useB ? int'(bApplied) : int'(aApplied);
    checkVal({tag, " value"}, cur, exp);
    checkVal({tag, " phase"}, int'(tbCnt), 0);
  endtask

  task automatic measureDuty(input int exp, input string tag);
    int cnt;
    cnt = 0;
    repeat (1024) begin
      @(negedge clk);
      cnt += int'(aPwm);
    end
    checkVal(tag, cnt, exp);
  endtask

  task automatic sendA(input logic [9:0] v);
    aCmd   = v;
    aValid = 1'b1;
    @(negedge clk);
    aValid = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; aCmd = 10'd0; bCmd = 10'd0;
    aValid = 1'b0; bValid = 1'b0; aClear = 1'b0; bClear = 1'b0;

    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst pwm", int'(aPwm), 0);
    checkVal("rst applied", int'(aApplied), 0);
    checkVal("rst ready", int'(aReady), 1);
    checkVal("rst err", int'(aErr), 0);
    rstN = 1'b1;

    // 2: command 30 -> 10, 20, 30 on successive wraps
    sendA(10'd30);
    checkVal("t2 ready low", int'(aReady), 0);
    waitStep(1'b0, 10, "t2 s1");
    checkVal("t2 busy", int'(aReady), 0);
    waitStep(1'b0, 20, "t2 s2");
    waitStep(1'b0, 30, "t2 s3");
    @(negedge clk);
    checkVal("t2 ready back", int'(aReady), 1);
    checkVal("t2 err", int'(aErr), 0);
    measureDuty(30, "t2 duty");

    // 4: 30 -> 25 (short step), then 25 -> 15, 5, 0
    sendA(10'd25);
    waitStep(1'b0, 25, "t4 pre");
    @(negedge clk);
    sendA(10'd0);
    waitStep(1'b0, 15, "t4 s1");
    waitStep(1'b0, 5, "t4 s2");
    waitStep(1'b0, 0, "t4 s3");
    @(negedge clk);
    checkVal("t4 ready", int'(aReady), 1);
    checkVal("t4 err", int'(aErr), 0);
    measureDuty(0, "t4 duty zero");

    // 3: clamp 1020 -> 1000 on instance B, steps 330/660/990/1000
    bCmd = 10'd1020; bValid = 1'b1;
    @(negedge clk);
    bValid = 1'b0;
    checkVal("t3 range err", int'(bErr), 1);
    waitStep(1'b1, 330, "t3 s1");
    waitStep(1'b1, 660, "t3 s2");
    waitStep(1'b1, 990, "t3 s3");
    waitStep(1'b1, 1000, "t3 s4");
    repeat (1100) @(negedge clk);
    checkVal("t3 hold", int'(bApplied), 1000);
    checkVal("t3 ready", int'(bReady), 1);
    bClear = 1'b1;
    @(negedge clk);
    bClear = 1'b0;
    checkVal("t3 clear", int'(bErr), 0);
    bCmd = 10'd1020; bValid = 1'b1; bClear = 1'b1;
    @(negedge clk);
    bValid = 1'b0; bClear = 1'b0;
    checkVal("t3 set wins", int'(bErr), 1);
    checkVal("t3 no slew", int'(bReady), 1);

    // 5: stall while slewing 0 -> 30 with CmdValid held high
    aCmd = 10'd30; aValid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4000; i++) begin
      if (aReady) break;
      @(negedge clk);
    end
    aValid = 1'b0;
    checkVal("t5 ready", int'(aReady), 1);
    checkVal("t5 applied", int'(aApplied), 30);
    @(negedge clk);
    checkVal("t5 stall err", int'(aErr), 2);
    aClear = 1'b1;
    @(negedge clk);
    aClear = 1'b0;
    checkVal("t5 clear", int'(aErr), 0);

    // 6: reset mid-slew at 20 toward 200
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    sendA(10'd200);
    waitStep(1'b0, 10, "t6 s1");
    waitStep(1'b0, 20, "t6 s2");
    rstN = 1'b0;
    @(negedge clk);
    checkVal("t6 applied", int'(aApplied), 0);
    checkVal("t6 ready", int'(aReady), 1);
    checkVal("t6 pwm", int'(aPwm), 0);
    checkVal("t6 err", int'(aErr), 0);
    rstN = 1'b1;
    repeat (1100) @(negedge clk);
    checkVal("t6 no resume", int'(aApplied), 0);
    measureDuty(0, "t6 duty");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
